// File: rtl/n_bit_serial_adder.sv
// -----------------------------------------------------------------------------
// n_bit_serial_adder
//
// Bit-serial N-bit adder. Two N-bit addends and a carry-in are latched when
// START is accepted in IDLE, then one bit is summed per clock (LSB first)
// through a single registered carry. After N SHIFT cycles the full sum is
// published on ANSWER/CARRY_OUT and DONE pulses for one cycle.
//
// Parameters:
//   N          operand/result width in bits (N >= 1)
//
// Ports:
//   CLK        system clock, all state updates on the rising edge
//   RST_N      synchronous active-low reset
//   START      request, only looked at while IDLE
//   INPUT1     first addend, captured when START is accepted
//   INPUT2     second addend, captured when START is accepted
//   CARRY_IN   initial carry, captured when START is accepted
//   BUSY       high while bits are being processed (SHIFT)
//   DONE       one-cycle pulse, ANSWER/CARRY_OUT valid
//   ANSWER     INPUT1 + INPUT2 + CARRY_IN modulo 2^N
//   CARRY_OUT  carry out of bit N-1
//   OVERFLOW   (only with SERIAL_ADDER_OVERFLOW_EN) signed two's-complement
//              overflow: carry into MSB XOR carry out of MSB
//
// Optional feature macro: SERIAL_ADDER_OVERFLOW_EN
// -----------------------------------------------------------------------------
module n_bit_serial_adder #(
  parameter int N = 3
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [N-1:0] INPUT1,
  input  logic [N-1:0] INPUT2,
  input  logic         CARRY_IN,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] ANSWER,
  output logic         CARRY_OUT
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic         OVERFLOW
`endif
);

  // Counter needs at least one bit so that N = 1 still elaborates.
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_reg;
  state_t          state_next;

  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;
  logic            c_reg;
  logic [N-1:0]    sum_reg;
  logic [CW-1:0]   cnt_reg;
  logic [N-1:0]    answer_reg;
  logic            carry_out_reg;

  logic            sum_bit;
  logic            carry_next;
  logic [N-1:0]    sum_shift;
  logic            last_bit;
  logic            busy_next;
  logic            done_next;

  // ---------------------------------------------------------------------------
  // Full-adder slice on the current LSBs. sum_shift is the result register
  // after this bit has been pushed into its MSB; it is written this way
  // (shift then overwrite MSB) so N = 1 needs no special slicing.
  // ---------------------------------------------------------------------------
  always_comb begin
    sum_bit    = a_reg[0] ^ b_reg[0] ^ c_reg;
    carry_next = (a_reg[0] & b_reg[0]) | (c_reg & (a_reg[0] ^ b_reg[0]));
    sum_shift          = sum_reg >> 1;
    sum_shift[N-1]     = sum_bit;
    last_bit   = (cnt_reg == CW'(N - 1));
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (START) begin
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy_next = 1'b1;
        if (last_bit) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done_next  = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign BUSY = busy_next;
  assign DONE = done_next;

  // ---------------------------------------------------------------------------
  // Datapath. ANSWER/CARRY_OUT are loaded only on the edge that completes the
  // last bit, so partial sums in sum_reg never reach the outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_reg         <= '0;
      b_reg         <= '0;
      c_reg         <= 1'b0;
      sum_reg       <= '0;
      cnt_reg       <= '0;
      answer_reg    <= '0;
      carry_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (START) begin
            a_reg   <= INPUT1;
            b_reg   <= INPUT2;
            c_reg   <= CARRY_IN;
            sum_reg <= '0;
            cnt_reg <= '0;
          end
        end
        S_SHIFT: begin
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          c_reg   <= carry_next;
          sum_reg <= sum_shift;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_bit) begin
            answer_reg    <= sum_shift;
            carry_out_reg <= carry_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ANSWER    = answer_reg;
  assign CARRY_OUT = carry_out_reg;

`ifdef SERIAL_ADDER_OVERFLOW_EN
  // On the last bit c_reg is the carry into the MSB and carry_next the carry
  // out of it; their XOR is the signed overflow.
  logic overflow_reg;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      overflow_reg <= 1'b0;
    end else if (state_reg == S_SHIFT && last_bit) begin
      overflow_reg <= c_reg ^ carry_next;
    end
  end

  assign OVERFLOW = overflow_reg;
`endif

endmodule

// File: tb/tb_n_bit_serial_adder.sv
module tb_n_bit_serial_adder;

  localparam int N = 3;
  localparam int TIMEOUT = 40;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic [N-1:0] INPUT1;
  logic [N-1:0] INPUT2;
  logic         CARRY_IN;
  logic         BUSY;
  logic         DONE;
  logic [N-1:0] ANSWER;
  logic         CARRY_OUT;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic         OVERFLOW;
`endif

  int checks = 0;
  int errors = 0;

  n_bit_serial_adder #(.N(N)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .START    (START),
    .INPUT1   (INPUT1),
    .INPUT2   (INPUT2),
    .CARRY_IN (CARRY_IN),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ANSWER   (ANSWER),
    .CARRY_OUT(CARRY_OUT)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .OVERFLOW (OVERFLOW)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int a;
    int b;
    int ci;
    int exp_ans;
    int exp_co;
    int exp_ov;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic int model_sum(input int a, input int b, input int ci);
    return a + b + ci;
  endfunction

  function automatic int model_ov(input int a, input int b, input int ci);
    int sa, sb, s;
    sa = (a >= (1 << (N - 1))) ? a - (1 << N) : a;
    sb = (b >= (1 << (N - 1))) ? b - (1 << N) : b;
    s  = sa + sb + ci;
    return (s > (1 << (N - 1)) - 1 || s < -(1 << (N - 1))) ? 1 : 0;
  endfunction

  // Called at the negedge right after the accepting edge. Counts clock
  // periods until DONE is seen and how many of them had BUSY high.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (DONE !== 1'b1 && lat < TIMEOUT) begin
      if (BUSY === 1'b1) busy_cnt++;
      @(negedge CLK);
      lat++;
    end
  endtask

  // One complete operation: accept, scramble inputs, wait for DONE, check.
  task automatic run_op(input string tag, input int a, input int b, input int ci,
                        input int exp_ans, input int exp_co, input int exp_ov);
    int lat, busy_cnt;
    @(negedge CLK);
    START = 1'b1;
    INPUT1 = N'(a);
    INPUT2 = N'(b);
    CARRY_IN = ci[0];
    @(negedge CLK);
    START = 1'b0;
    INPUT1 = N'($urandom);
    INPUT2 = N'($urandom);
    CARRY_IN = 1'($urandom);
    wait_done(lat, busy_cnt);
    chk({tag, " latency"}, lat, N);
    chk({tag, " busy_cycles"}, busy_cnt, N);
    chk({tag, " answer"}, int'(ANSWER), exp_ans);
    chk({tag, " carry_out"}, int'(CARRY_OUT), exp_co);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk({tag, " overflow"}, int'(OVERFLOW), exp_ov);
`endif
    $display("op %s: %0d + %0d + %0d -> answer=%0d carry=%0d (lat %0d)",
             tag, a, b, ci, ANSWER, CARRY_OUT, lat);
    @(negedge CLK);
    chk({tag, " done_single"}, int'(DONE), 0);
    chk({tag, " answer_hold"}, int'(ANSWER), exp_ans);
  endtask

  vec_t vecs[6];

  initial begin
    int lat, busy_cnt, seen_done;

    vecs[0] = '{a: 3, b: 2, ci: 0, exp_ans: 5, exp_co: 0, exp_ov: 1};
    vecs[1] = '{a: 7, b: 1, ci: 0, exp_ans: 0, exp_co: 1, exp_ov: 0};
    vecs[2] = '{a: 5, b: 5, ci: 1, exp_ans: 3, exp_co: 1, exp_ov: 1};
    vecs[3] = '{a: 6, b: 1, ci: 0, exp_ans: 7, exp_co: 0, exp_ov: 0};
    vecs[4] = '{a: 3, b: 1, ci: 0, exp_ans: 4, exp_co: 0, exp_ov: 1};
    vecs[5] = '{a: 7, b: 7, ci: 0, exp_ans: 6, exp_co: 1, exp_ov: 0};

    START = 1'b0;
    INPUT1 = '0;
    INPUT2 = '0;
    CARRY_IN = 1'b0;
    RST_N = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    chk("reset busy", int'(BUSY), 0);
    chk("reset done", int'(DONE), 0);
    chk("reset answer", int'(ANSWER), 0);
    chk("reset carry_out", int'(CARRY_OUT), 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk("reset overflow", int'(OVERFLOW), 0);
`endif
    $display("reset: busy=%0d done=%0d answer=%0d carry=%0d", BUSY, DONE, ANSWER, CARRY_OUT);

    // Directed table
    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci,
             vecs[i].exp_ans, vecs[i].exp_co, vecs[i].exp_ov);
    end

    // START pulsed during SHIFT must be ignored
    @(negedge CLK);
    START = 1'b1; INPUT1 = 3'd3; INPUT2 = 3'd2; CARRY_IN = 1'b0;
    @(negedge CLK);
    INPUT1 = 3'd6; INPUT2 = 3'd6; CARRY_IN = 1'b1;   // START still high in SHIFT
    @(negedge CLK);
    START = 1'b0;
    lat = 1; busy_cnt = 1;
    while (DONE !== 1'b1 && lat < TIMEOUT) begin
      if (BUSY === 1'b1) busy_cnt++;
      @(negedge CLK);
      lat++;
    end
    chk("ignore latency", lat, N);
    chk("ignore answer", int'(ANSWER), 5);
    chk("ignore carry_out", int'(CARRY_OUT), 0);
    $display("ignore-start: answer=%0d carry=%0d", ANSWER, CARRY_OUT);
    seen_done = 0;
    repeat (N + 4) begin
      @(negedge CLK);
      if (DONE === 1'b1) seen_done++;
    end
    chk("ignore extra_done", seen_done, 0);

    // START held high: back-to-back ops, period N+2
    START = 1'b1; INPUT1 = 3'd1; INPUT2 = 3'd1; CARRY_IN = 1'b0;
    @(negedge CLK);
    INPUT1 = 3'd3; INPUT2 = 3'd3; CARRY_IN = 1'b0;
    wait_done(lat, busy_cnt);
    chk("b2b first latency", lat, N);
    chk("b2b first answer", int'(ANSWER), 2);
    @(negedge CLK);
    chk("b2b idle busy", int'(BUSY), 0);
    chk("b2b idle done", int'(DONE), 0);
    @(negedge CLK);
    chk("b2b restart busy", int'(BUSY), 1);
    START = 1'b0;
    wait_done(lat, busy_cnt);
    chk("b2b second latency", lat, N);
    chk("b2b second answer", int'(ANSWER), 6);
    chk("b2b second carry_out", int'(CARRY_OUT), 0);
    $display("back-to-back: second answer=%0d", ANSWER);
    @(negedge CLK);

    // Reset in the 2nd SHIFT cycle of 6+1
    START = 1'b1; INPUT1 = 3'd6; INPUT2 = 3'd1; CARRY_IN = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    chk("midreset busy", int'(BUSY), 0);
    chk("midreset done", int'(DONE), 0);
    chk("midreset answer", int'(ANSWER), 0);
    chk("midreset carry_out", int'(CARRY_OUT), 0);
    seen_done = 0;
    repeat (N + 4) begin
      @(negedge CLK);
      if (DONE === 1'b1) seen_done++;
    end
    chk("midreset no_done", seen_done, 0);
    chk("midreset answer_after", int'(ANSWER), 0);
    $display("mid-reset: answer=%0d done_pulses=%0d", ANSWER, seen_done);
    run_op("after_reset", 6, 1, 0, 7, 0, 0);

    // Randomised against the arithmetic model
    for (int r = 0; r < 25; r++) begin
      int a, b, ci, s;
      a  = int'($urandom_range((1 << N) - 1, 0));
      b  = int'($urandom_range((1 << N) - 1, 0));
      ci = int'($urandom_range(1, 0));
      s  = model_sum(a, b, ci);
      run_op($sformatf("rnd%0d", r), a, b, ci, s % (1 << N), s >> N,
             model_ov(a, b, ci));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/n_bit_serial_adder.md
Name: n_bit_serial_adder

Overview:
- Bit-serial N-bit adder: the addition counterpart of the ripple-borrow N_BIT_SUBSTRACTOR datapath.
- Latches two N-bit operands on a START request and processes one bit per clock, LSB first, using a registered carry.
- Reports ANSWER and CARRY_OUT with a one-cycle DONE pulse.
- Used in the lab arithmetic unit where area matters more than latency, alongside the combinational subtractor.

Parameters:
- N, 3, operand/result width in bits; legal range N >= 1.

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RST_N  input  1  synchronous active-low reset, sampled on rising edge of CLK
- START  input  1  request; sampled only in IDLE
- INPUT1  input  N  first addend; captured when START is accepted
- INPUT2  input  N  second addend; captured when START is accepted
- CARRY_IN  input  1  initial carry; captured when START is accepted
- BUSY  output  1  high while in SHIFT
- DONE  output  1  one-cycle pulse; result valid
- ANSWER  output  N  sum, INPUT1 + INPUT2 + CARRY_IN modulo 2^N
- CARRY_OUT  output  1  carry out of bit N-1

Behaviour:
- Clocking and reset: single clock domain, CLK. Reset is synchronous and active-low on RST_N.
- Reset values (RST_N low at an edge):
  - state = IDLE; BUSY = 0; DONE = 0; ANSWER = 0; CARRY_OUT = 0
  - internal operand shift registers = 0; carry reg = 0; bit counter = 0
- Reset mid-operation: the operation is abandoned, no DONE is produced, and all outputs take their reset values at that edge.
- State IDLE:
  - On an edge with START = 1: load INPUT1/INPUT2 into shift regs, load carry reg = CARRY_IN, counter = 0, go to SHIFT.
  - Otherwise remain in IDLE. ANSWER and CARRY_OUT hold the previous result.
- State SHIFT, per edge:
  - s = A[0] ^ B[0] ^ c
  - c_next = (A[0] & B[0]) | (c & (A[0] ^ B[0]))
  - s is shifted into the MSB of the result register, which shifts right. A and B shift right.
  - counter increments.
  - When counter == N-1 at the edge (the Nth bit is processed), go to DONE.
- State DONE:
  - DONE = 1 for exactly one cycle.
  - ANSWER = full sum (bit i holds bit i of the sum); CARRY_OUT = final carry.
  - Next edge goes to IDLE.
- Latency: START accepted at edge k gives BUSY high for cycles k+1 .. k+N and DONE high in the cycle after edge k+N. Total N+1 edges from accept to DONE.
- ANSWER/CARRY_OUT register updates:
  - ANSWER and CARRY_OUT update only on the edge entering DONE. The result register is internal; ANSWER must not show partial sums.
  - Both hold stable until the next DONE or reset.
- START handling outside IDLE:
  - START while in SHIFT or DONE is ignored (no queueing).
  - START held high continuously restarts on the first IDLE cycle after DONE, giving back-to-back operations every N+2 cycles.
- Operand inputs may change freely after the accepting edge without affecting the result.
- Counter width is $clog2(N), minimum 1. N = 1 is legal: one SHIFT cycle, then DONE.
- Wrap-around: the sum is modulo 2^N, and the overflow into bit N appears only on CARRY_OUT.

Optional Feature:
- Macro: SERIAL_ADDER_OVERFLOW_EN
- Defined:
  - Adds output port OVERFLOW (1 bit), signed two's-complement overflow = carry into MSB XOR carry out of MSB.
  - Captured on the edge entering DONE, held with ANSWER, reset value 0.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- N=3, RST_N=0 for 2 edges, then release → BUSY=0, DONE=0, ANSWER=3'b000, CARRY_OUT=0.
- START with INPUT1=3, INPUT2=2, CARRY_IN=0 → BUSY high 3 cycles, DONE pulses once in 4th cycle after accept, ANSWER=5, CARRY_OUT=0.
- INPUT1=7, INPUT2=1, CARRY_IN=0 → ANSWER=0, CARRY_OUT=1. Then INPUT1=5, INPUT2=5, CARRY_IN=1 → ANSWER=3, CARRY_OUT=1.
- START pulsed again during SHIFT with different operands → ignored; first result (e.g. 3+2 → 5) delivered, only one DONE pulse. START held high → second op begins on the IDLE cycle after DONE.
- RST_N=0 at 2nd SHIFT cycle of 6+1 → no DONE ever pulses, ANSWER=0, state IDLE. A subsequent 6+1 → ANSWER=7, CARRY_OUT=0.
- With SERIAL_ADDER_OVERFLOW_EN:
  - 3+1 (signed 3+1) → ANSWER=3'b100, OVERFLOW=1, CARRY_OUT=0.
  - 7+7 (-1 + -1) → ANSWER=6, OVERFLOW=0, CARRY_OUT=1.
